// File: rtl/tff_toggle_gen.sv
// Debounced toggle-pulse generator feeding a downstream T flip-flop.
// Synchronises a raw button, debounces both edges and emits one-cycle pulses.
module tff_toggle_gen #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_CYCLES   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_btn,
   output logic       o_t,
   output logic       o_busy,
   output logic [7:0] o_press_cnt
);

   localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_DB_PRESS   = 2'd1;
   localparam logic [1:0] ST_HELD       = 2'd2;
   localparam logic [1:0] ST_DB_RELEASE = 2'd3;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             t_q, t_d;
   logic             busy_q, busy_d;
   logic [7:0]       press_cnt_q, press_cnt_d;
   logic             btn_s;
   logic             pulse;

   assign btn_s = sync2_q;

   // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
   always_comb begin
      sync1_d = i_btn;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (btn_s) begin
               state_d = ST_DB_PRESS;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end

         // The level test is evaluated before the terminal count, so a bounce always wins.
         ST_DB_PRESS: begin
            if (!btn_s) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_HELD;
               cnt_d   = '0;
               pulse   = 1'b1;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         ST_HELD: begin
            if (!btn_s) begin
               state_d = ST_DB_RELEASE;
               cnt_d   = CNT_ONE;
            end else if (REPEAT_EN && (cnt_q == REP_LAST)) begin
               cnt_d   = '0;
               pulse   = 1'b1;
            end else if (REPEAT_EN) begin
               cnt_d   = cnt_q + CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end

         ST_DB_RELEASE: begin
            if (btn_s) begin
               state_d = ST_HELD;
               cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      t_d         = pulse;
      busy_d      = (state_d != ST_IDLE);
      press_cnt_d = pulse ? press_cnt_q + 8'd1 : press_cnt_q;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         t_q         <= 1'b0;
         busy_q      <= 1'b0;
         press_cnt_q <= 8'd0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         t_q         <= t_d;
         busy_q      <= busy_d;
         press_cnt_q <= press_cnt_d;
      end
   end

   assign o_t         = t_q;
   assign o_busy      = busy_q;
   assign o_press_cnt = press_cnt_q;

endmodule

// File: tb/tb_tff_toggle_gen.sv
// Directed bench for tff_toggle_gen: one non-repeating and one auto-repeat instance.
module tb_tff_toggle_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn;
   logic       btn_r;
   logic       o_t, o_busy;
   logic [7:0] o_press_cnt;
   logic       o_t_r, o_busy_r;
   logic [7:0] o_press_cnt_r;
   logic       tq;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   tff_toggle_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .i_btn(btn),
      .o_t(o_t), .o_busy(o_busy), .o_press_cnt(o_press_cnt)
   );

   tff_toggle_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_CYCLES(8)) dut_r (
      .clk(clk), .reset(reset), .i_btn(btn_r),
      .o_t(o_t_r), .o_busy(o_busy_r), .o_press_cnt(o_press_cnt_r)
   );

   // Downstream T flip-flop model
   always @(posedge clk) begin
      if (reset) tq <= 1'b0;
      else if (o_t) tq <= ~tq;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance n edges with the button already driven; o_t must be high only at pulse_edge (0 = never).
   task automatic pulse_window(input string tag, input int n, input int pulse_edge);
      for (int e = 1; e <= n; e++) begin
         tick();
         check(tag, {31'd0, o_t}, {31'd0, (e == pulse_edge)});
      end
   endtask

   task automatic release_idle(input string tag);
      btn = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         check(tag, {31'd0, o_busy}, {31'd0, (e < 6)});
         check(tag, {31'd0, o_t}, 32'd0);
      end
   endtask

   initial begin
      logic tq0;
      reset = 1'b1;
      btn   = 1'b1;
      btn_r = 1'b0;

      // Reset with the button held
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_o_t", {31'd0, o_t}, 32'd0);
         check("rst_busy", {31'd0, o_busy}, 32'd0);
         check("rst_cnt", {24'd0, o_press_cnt}, 32'd0);
      end
      reset = 1'b0;
      pulse_window("rst_held_pulse", 10, 6);
      check("rst_held_cnt", {24'd0, o_press_cnt}, 32'd1);
      release_idle("rst_held_release");

      // Clean press held 20 cycles
      tq0 = tq;
      btn = 1'b1;
      pulse_window("clean_pulse", 20, 6);
      check("clean_cnt", {24'd0, o_press_cnt}, 32'd2);
      check("clean_tff", {31'd0, tq}, {31'd0, ~tq0});
      release_idle("clean_release");

      // Press bounce: high for 3 cycles; the bounce lands on the terminal-count edge
      btn = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (e == 3) btn = 1'b0;
         check("bounce_o_t", {31'd0, o_t}, 32'd0);
         check("bounce_busy", {31'd0, o_busy}, {31'd0, (e >= 3 && e <= 5)});
      end
      check("bounce_cnt", {24'd0, o_press_cnt}, 32'd2);

      // Release glitch: low for 2 cycles then high again
      btn = 1'b1;
      pulse_window("glitch_first", 10, 6);
      btn = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (e == 2) btn = 1'b1;
         check("glitch_o_t", {31'd0, o_t}, 32'd0);
         check("glitch_busy", {31'd0, o_busy}, 32'd1);
      end
      check("glitch_cnt", {24'd0, o_press_cnt}, 32'd3);
      release_idle("glitch_release");

      // Counter wrap after 256 presses from zero
      reset = 1'b1;
      tick();
      check("wrap_rst_cnt", {24'd0, o_press_cnt}, 32'd0);
      reset = 1'b0;
      for (int p = 0; p < 255; p++) begin
         btn = 1'b1;
         repeat (8) tick();
         btn = 1'b0;
         repeat (8) tick();
      end
      check("wrap_255", {24'd0, o_press_cnt}, 32'd255);
      btn = 1'b1;
      repeat (8) tick();
      btn = 1'b0;
      repeat (8) tick();
      check("wrap_0", {24'd0, o_press_cnt}, 32'd0);

      // Reset at edge 4 of a press, button kept held through and after reset
      btn = 1'b1;
      repeat (3) tick();
      check("midrst_busy_pre", {31'd0, o_busy}, 32'd1);
      reset = 1'b1;
      tick();
      check("midrst_o_t", {31'd0, o_t}, 32'd0);
      check("midrst_busy", {31'd0, o_busy}, 32'd0);
      check("midrst_cnt", {24'd0, o_press_cnt}, 32'd0);
      reset = 1'b0;
      pulse_window("midrst_repress", 10, 6);
      check("midrst_cnt_after", {24'd0, o_press_cnt}, 32'd1);
      release_idle("midrst_release");

      // Auto-repeat instance: held 30 cycles
      check("rep_idle_busy", {31'd0, o_busy_r}, 32'd0);
      btn_r = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         tick();
         check("rep_o_t", {31'd0, o_t_r}, {31'd0, (e == 6 || e == 14 || e == 22 || e == 30)});
      end
      check("rep_cnt", {24'd0, o_press_cnt_r}, 32'd4);
      btn_r = 1'b0;
      repeat (8) tick();
      check("rep_busy_end", {31'd0, o_busy_r}, 32'd0);
      check("rep_cnt_end", {24'd0, o_press_cnt_r}, 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tff_toggle_gen.md
# tff_toggle_gen

Debounced toggle-pulse generator that sits directly upstream of the `tff` stage and drives its `i_t` input from a raw, asynchronous push-button or level source. It synchronises the input and debounces both edges with a state machine. It emits exactly one single-cycle `o_t` pulse per accepted press, or a periodic pulse train while the button is held if auto-repeat is enabled. As a result, the downstream `o_q` toggles exactly once per clean press.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples needed to accept a press or a release; minimum 2.
- `REPEAT_EN`, default 0: 1 enables auto-repeat pulses while held.
- `REPEAT_CYCLES`, default 8: period between repeat pulses, in clk cycles; minimum 2; ignored when `REPEAT_EN`=0.
- `clk`  input  1  sole clock; all flops on its rising edge.
- `reset`  input  1  synchronous, active-high; clears every flop.
- `i_btn`  input  1  raw asynchronous button level; 1 = pressed.
- `o_t`  output  1  toggle pulse to `tff.i_t`; registered; high for exactly one cycle per event.
- `o_busy`  output  1  registered; 1 whenever the FSM is not in IDLE.
- `o_press_cnt`  output  8  registered count of `o_t` pulses emitted; wraps from 255 to 0.

## Operation
- Synchroniser: two flops on `i_btn`, both reset to 0; the FSM only uses `btn_s`, the second-stage value.
- Internal counter `cnt` must be wide enough for max(`DEBOUNCE_CYCLES`, `REPEAT_CYCLES`); it resets to 0.
- `o_t` defaults to 0 each cycle and is set only on the transitions marked PULSE below.
- Every PULSE also increments `o_press_cnt` modulo 256.
- FSM states and transitions (evaluated every edge):
  - IDLE:
    - `btn_s`=1 → DB_PRESS, cnt=1.
    - Otherwise stay, cnt=0.
  - DB_PRESS:
    - `btn_s`=0 → IDLE, cnt=0 (bounce; no pulse).
    - `btn_s`=1 and cnt==D-1 → HELD, cnt=0, PULSE.
    - Otherwise cnt++.
  - HELD:
    - `btn_s`=0 → DB_RELEASE, cnt=1.
    - `btn_s`=1 and `REPEAT_EN` and cnt==R-1 → stay, cnt=0, PULSE.
    - `btn_s`=1 otherwise: cnt++ if `REPEAT_EN`; hold cnt at 0 if not.
  - DB_RELEASE:
    - `btn_s`=1 → HELD, cnt=0 (release glitch; no pulse).
    - `btn_s`=0 and cnt==D-1 → IDLE, cnt=0.
    - Otherwise cnt++.
- `o_busy` is registered alongside the state register: it is 1 in every state except IDLE.
- Reset while in any state: the FSM goes to IDLE and no pulse is emitted.
  - Any in-progress debounce is discarded.
  - After reset, a button that is still held must complete the full synchroniser plus debounce sequence again.

## Timing
- Reset values: `o_t`=0, `o_busy`=0, `o_press_cnt`=0, state=IDLE, cnt=0, both synchroniser flops=0.
- Press latency: `i_btn` rises before edge 1 → `btn_s`=1 after edge 2 → DB_PRESS at edge 3 → PULSE at edge 2+D. With D=4, `o_t` is high for the cycle following edge 6.
- Release latency: `i_btn` falls before edge 1 → DB_RELEASE at edge 3 → IDLE at edge 2+D. `o_busy` falls at that same edge.
- Repeat: pulses are spaced exactly R cycles apart. The first repeat pulse comes R edges after the initial pulse.
- `o_t` is never high on two consecutive cycles, because D ≥ 2 and R ≥ 2.
- When a bounce and a counter terminal value occur at the same edge, the `btn_s` level test takes priority, as written above.

## Test plan
Unless stated otherwise, parameters are D=4, REPEAT_EN=0, with a 10 ns clock. Edge numbers are counted from the first edge after the `i_btn` change.
- Reset with button held: `reset`=1 for 2 cycles with `i_btn`=1.
  - During reset: `o_t`=0, `o_busy`=0, `o_press_cnt`=0.
  - After deassertion: exactly one `o_t` pulse, on the 6th edge.
- Clean press: `i_btn` goes 0→1, is held 20 cycles, then released.
  - One `o_t` pulse, 1 cycle wide, at edge 6; `o_press_cnt`=1.
  - `o_busy` falls on the 6th edge after the release.
  - With `tff` attached, `o_q` toggles exactly once.
- Press bounce: `i_btn` high for 3 cycles, then low.
  - No `o_t` pulse; `o_press_cnt` unchanged.
  - `o_busy` pulses high, then returns to 0.
- Release glitch: held, then `i_btn` low for 2 cycles, then high again for 10 cycles.
  - No second pulse; FSM returns to HELD.
  - `o_press_cnt` increments by only 1 overall.
- Auto-repeat: REPEAT_EN=1, R=8, `i_btn` held 30 cycles.
  - Pulses at edges 6, 14, 22 and 30; `o_press_cnt`=4.
- Wrap and reset mid-debounce:
  - 256 clean presses → `o_press_cnt` reads 0.
  - `reset` asserted at edge 4 of a press → no pulse, count unchanged.
